fp32_class_stats: RTL and testbench

Streaming statistics collector sitting directly downstream of the FP32 classifier stage. It accepts one 10-bit class-flag vector per handshake and keeps a saturating occurrence counter per IEEE 754 category plus a total. It also keeps sticky NaN indicators and exposes a registered read port for software or debug readout. Typical use: profiling operand streams feeding the FP32 datapath and flagging signaling NaNs.

---
 rtl/fp32_class_stats.sv | 89 ++++++++
 tb/tb_fp32_class_stats.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp32_class_stats.sv
// fp32_class_stats: saturating per-category counters and a total for FP32 class flags,
// sticky NaN flags, registered read port. Optional check: FP32_CLASS_STATS_ONEHOT_CHECK_EN.
module fp32_class_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_class,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [3:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W+3:0] rd_data,
  output logic             nan_seen,
  output logic             snan_seen,
  output logic             class_err
);
  localparam int         TOT_W     = CNT_W + 4;
  localparam int         NCAT      = 10;
  localparam logic [3:0] SEL_TOTAL = 4'd10;

  logic [CNT_W-1:0] cnt [NCAT];
  logic [TOT_W-1:0] total;
  logic [TOT_W-1:0] rd_mux;
  logic [9:0]       cnt_inc;
  logic             accept;
  logic             class_ok;

  assign in_ready = !rst && !clear;
  assign accept   = in_valid && in_ready;

`ifdef FP32_CLASS_STATS_ONEHOT_CHECK_EN
  logic onehot;
  assign onehot   = (in_class != '0) && ((in_class & (in_class - 10'd1)) == '0);
  assign class_ok = onehot;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) class_err <= 1'b0;
    else if (accept && !onehot) class_err <= 1'b1;
  end
`else
  assign class_ok  = 1'b1;
  assign class_err = 1'b0;
`endif

  // A rejected (non-one-hot) beat touches no category counter and no NaN flag.
  assign cnt_inc = (accept && class_ok) ? in_class : '0;

  // NOTE: the counter array is built from flops, not RAM, so it is reset with everything else.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NCAT; i++) cnt[i] <= '0;
      total     <= '0;
      nan_seen  <= 1'b0;
      snan_seen <= 1'b0;
    end else begin
      for (int i = 0; i < NCAT; i++) begin
        if (cnt_inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
      if (accept && (total != '1)) total <= total + 1'b1;
      if (cnt_inc[9] || cnt_inc[8]) nan_seen  <= 1'b1;
      if (cnt_inc[9])               snan_seen <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default assigned first so every path drives rd_mux and no latch is inferred.
    rd_mux = '0;
    for (int i = 0; i < NCAT; i++) begin
      if (rd_sel == 4'(i)) rd_mux = {4'b0000, cnt[i]};
    end
    if (rd_sel == SEL_TOTAL) rd_mux = total;
  end

  // Read samples the counters as registered, so a same-cycle increment or clear is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_fp32_class_stats.sv
// Self-checking bench for fp32_class_stats: directed literal cases plus randomized traffic
// compared every cycle against a queue-free arithmetic model of the counters and flags.
`timescale 1ns/1ps
module tb_fp32_class_stats;
  localparam int CNT_W   = 4;
  localparam int TOT_W   = CNT_W + 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int TOT_MAX = (1 << TOT_W) - 1;
`ifdef FP32_CLASS_STATS_ONEHOT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, in_valid, clear, rd_req;
  logic [9:0]       in_class;
  logic [3:0]       rd_sel;
  logic             in_ready, rd_valid, nan_seen, snan_seen, class_err;
  logic [TOT_W-1:0] rd_data;

  int checks   = 0;
  int failures = 0;

  fp32_class_stats #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
    .nan_seen(nan_seen), .snan_seen(snan_seen), .class_err(class_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: counts, totals and flags straight from the category rules.
  int m_cnt [10];
  int m_total;
  bit m_nan, m_snan, m_err, m_ok;
  bit exp_rd_valid;
  int exp_rd_data;
  bit started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) m_cnt[i] = 0;
      m_total = 0; m_nan = 0; m_snan = 0; m_err = 0;
      exp_rd_valid = 0; exp_rd_data = 0;
      started = 1'b1;
    end else begin
      exp_rd_valid = rd_req;
      if (rd_req) begin
        if (rd_sel < 10)       exp_rd_data = m_cnt[rd_sel];
        else if (rd_sel == 10) exp_rd_data = m_total;
        else                   exp_rd_data = 0;
      end
      if (clear) begin
        for (int i = 0; i < 10; i++) m_cnt[i] = 0;
        m_total = 0; m_nan = 0; m_snan = 0; m_err = 0;
      end else if (in_valid) begin
        m_ok    = !CHECK_EN || ($countones(in_class) == 1);
        m_total = (m_total < TOT_MAX) ? m_total + 1 : TOT_MAX;
        if (!m_ok) m_err = 1;
        else begin
          for (int i = 0; i < 10; i++)
            if (in_class[i]) m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
          if (in_class[9] || in_class[8]) m_nan = 1;
          if (in_class[9]) m_snan = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", in_ready, !rst && !clear);
      check("rd_valid", rd_valid, exp_rd_valid);
      if (exp_rd_valid) check("rd_data", rd_data, exp_rd_data);
      check("nan_seen", nan_seen, m_nan);
      check("snan_seen", snan_seen, m_snan);
      check("class_err", class_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [3:0] sel, input int exp);
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
    check($sformatf("%s_valid_sel%0d", name, sel), rd_valid, 1'b1);
    check($sformatf("%s_data_sel%0d", name, sel), rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_class = '0; clear = 1'b0; rd_req = 1'b0; rd_sel = '0;
    repeat (3) tick();
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 0);
    check("rst_nan", nan_seen, 1'b0);
    check("rst_snan", snan_seen, 1'b0);
    check("rst_err", class_err, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", in_ready, 1'b1);

    // One beat per category, then read every counter and the total.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_class = 10'b1 << i;
      tick();
    end
    in_valid = 1'b0;
    for (int s = 0; s <= 10; s++) check_read("walk", 4'(s), (s < 10) ? 1 : 10);
    check_read("reserved", 4'd12, 0);
    check("walk_nan", nan_seen, 1'b1);
    check("walk_snan", snan_seen, 1'b1);
    check("walk_err", class_err, 1'b0);

    // Clear with a beat offered: not accepted, everything reads zero afterwards.
    in_valid = 1'b1; in_class = 10'h002; clear = 1'b1;
    #1;
    check("clear_ready", in_ready, 1'b0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    for (int s = 0; s <= 10; s++) check_read("clr", 4'(s), 0);
    check("clr_nan", nan_seen, 1'b0);

    // Saturation of a 4-bit category counter; total keeps counting.
    in_valid = 1'b1; in_class = 10'h002;
    repeat (20) tick();
    in_valid = 1'b0;
    check_read("sat", 4'd1, 15);
    check_read("sat_total", 4'd10, 20);

    // Read coinciding with the 3rd accept sees the pre-increment value.
    do_clear();
    in_valid = 1'b1; in_class = 10'h100;
    tick(); tick();
    rd_req = 1'b1; rd_sel = 4'd8;
    tick();
    rd_req = 1'b0;
    check("qnan_mid_valid", rd_valid, 1'b1);
    check("qnan_mid_data", rd_data, 2);
    tick(); tick();
    in_valid = 1'b0;
    check_read("qnan_full", 4'd8, 5);

    // Non-one-hot beats.
    do_clear();
    in_valid = 1'b1; in_class = 10'h003; tick();
    in_class = 10'h000; tick();
    in_valid = 1'b0;
    check_read("oh", 4'd0, CHECK_EN ? 0 : 1);
    check_read("oh", 4'd1, CHECK_EN ? 0 : 1);
    check_read("oh_total", 4'd10, 2);
    check("oh_err", class_err, CHECK_EN);

    // Randomized traffic, checked by the per-cycle compare process.
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 1499) == 0);
      clear    = ($urandom_range(0, 499) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0, 1:    in_class = 10'b1 << $urandom_range(0, 9);
        2:       in_class = 10'($urandom);
        default: in_class = '0;
      endcase
      rd_req = $urandom_range(0, 1);
      rd_sel = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; clear = 1'b0;

    // Reset mid-stream with a read in flight.
    in_valid = 1'b1; in_class = 10'h200; rd_req = 1'b1; rd_sel = 4'd10;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_rd_valid", rd_valid, 1'b0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_nan", nan_seen, 1'b0);
    check("mid_rst_snan", snan_seen, 1'b0);
    check("mid_rst_err", class_err, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    tick();
    check("mid_rst_ready2", in_ready, 1'b0);
    rst = 1'b0; in_valid = 1'b0; rd_req = 1'b0;
    #1;
    check("mid_rst_ready_back", in_ready, 1'b1);
    for (int s = 0; s <= 10; s++) check_read("post_rst", 4'(s), 0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
